// File: rtl/time_report_tx.sv
// Serialises a frozen BCD time-of-day snapshot as "HH:MM:SS[.CC]<CR><LF>" into a
// TX FIFO write port, one byte per cycle unless the FIFO reports full.
module time_report_tx #(
  parameter bit          SHOW_MSEC = 1'b1,
  parameter bit          SEND_CRLF = 1'b1,
  parameter int unsigned DROP_W    = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_trig,
  input  logic              i_enable,
  input  logic [3:0]        hour1,
  input  logic [3:0]        hour0,
  input  logic [3:0]        min1,
  input  logic [3:0]        min0,
  input  logic [3:0]        sec1,
  input  logic [3:0]        sec0,
  input  logic [3:0]        msec1,
  input  logic [3:0]        msec0,
  input  logic              i_full,
  output logic [7:0]        o_data,
  output logic              o_push,
  output logic              o_busy,
  output logic              o_done,
  output logic [DROP_W-1:0] o_drop_cnt
);

  localparam int unsigned TermIdx  = SHOW_MSEC ? 11 : 8;
  localparam int unsigned FrameLen = TermIdx + (SEND_CRLF ? 2 : 1);
  localparam logic [3:0]  LastIdx  = 4'(FrameLen - 1);
  localparam logic [3:0]  TermIdxL = 4'(TermIdx);

  typedef enum logic [1:0] {StIdle, StSend, StDone} state_e;

  state_e             state_q, state_d;
  logic [31:0]        snap_q, snap_d;
  logic [3:0]         idx_q, idx_d;
  logic [DROP_W-1:0]  drop_q, drop_d;
  logic               accept;
  logic               push;
  logic [7:0]         byte_sel;

  function automatic logic [7:0] enc(input logic [3:0] d);
    return (d > 4'd9) ? 8'h3F : (8'h30 + {4'h0, d});
  endfunction

  assign accept = i_trig & i_enable;
  assign push   = (state_q == StSend) && !i_full;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      snap_q  <= '0;
      idx_q   <= '0;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      snap_q  <= snap_d;
      idx_q   <= idx_d;
      drop_q  <= drop_d;
    end
  end

  always_comb begin
    state_d = state_q;
    snap_d  = snap_q;
    idx_d   = idx_q;
    drop_d  = drop_q;
    case (state_q)
      StIdle: begin
        if (accept) begin
          snap_d  = {hour1, hour0, min1, min0, sec1, sec0, msec1, msec0};
          idx_d   = '0;
          state_d = StSend;
        end
      end
      StSend: begin
        if (push) begin
          idx_d = idx_q + 4'd1;
          if (idx_q == LastIdx) state_d = StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
    // Triggers are never queued; those arriving mid-frame are only counted.
    if (accept && (state_q != StIdle) && (drop_q != {DROP_W{1'b1}})) begin
      drop_d = drop_q + DROP_W'(1);
    end
  end

  always_comb begin
    byte_sel = 8'h0A;
    case (idx_q)
      4'd0: byte_sel = enc(snap_q[31:28]);
      4'd1: byte_sel = enc(snap_q[27:24]);
      4'd2: byte_sel = 8'h3A;
      4'd3: byte_sel = enc(snap_q[23:20]);
      4'd4: byte_sel = enc(snap_q[19:16]);
      4'd5: byte_sel = 8'h3A;
      4'd6: byte_sel = enc(snap_q[15:12]);
      4'd7: byte_sel = enc(snap_q[11:8]);
      default: begin
        if (SHOW_MSEC && idx_q == 4'd8)       byte_sel = 8'h2E;
        else if (SHOW_MSEC && idx_q == 4'd9)  byte_sel = enc(snap_q[7:4]);
        else if (SHOW_MSEC && idx_q == 4'd10) byte_sel = enc(snap_q[3:0]);
        else if (SEND_CRLF && idx_q == TermIdxL) byte_sel = 8'h0D;
        else                                   byte_sel = 8'h0A;
      end
    endcase
  end

  always_comb begin
    o_push     = push;
    o_data     = (state_q == StSend) ? byte_sel : 8'h00;
    o_busy     = (state_q != StIdle);
    o_done     = (state_q == StDone);
    o_drop_cnt = drop_q;
  end

endmodule

// File: tb/tb_time_report_tx.sv
// Directed bench for time_report_tx: a default-parameter instance and a
// SHOW_MSEC=0 / SEND_CRLF=0 instance, checked against hand-computed byte streams.
module tb_time_report_tx;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       trig_a = 1'b0, trig_b = 1'b0, en = 1'b1;
  logic       full_a = 1'b0, full_b = 1'b0;
  logic [3:0] hour1 = 0, hour0 = 0, min1 = 0, min0 = 0;
  logic [3:0] sec1 = 0, sec0 = 0, msec1 = 0, msec0 = 0;

  logic [7:0] data_a, data_b;
  logic       push_a, push_b, busy_a, busy_b, done_a, done_b;
  logic [7:0] drop_a, drop_b;

  int n_checks = 0;
  int n_fail   = 0;
  int busy_cnt_a = 0;
  logic [7:0] qa[$];

  logic [7:0] exp1 [13] = '{8'h31, 8'h32, 8'h3A, 8'h33, 8'h34, 8'h3A, 8'h35,
                            8'h36, 8'h2E, 8'h37, 8'h38, 8'h0D, 8'h0A};
  logic [7:0] exp2 [9]  = '{8'h32, 8'h33, 8'h3A, 8'h35, 8'h39, 8'h3A, 8'h35,
                            8'h39, 8'h0A};

  time_report_tx #(.SHOW_MSEC(1'b1), .SEND_CRLF(1'b1), .DROP_W(8)) dut (
    .clk(clk), .rst(rst), .i_trig(trig_a), .i_enable(en),
    .hour1(hour1), .hour0(hour0), .min1(min1), .min0(min0),
    .sec1(sec1), .sec0(sec0), .msec1(msec1), .msec0(msec0),
    .i_full(full_a), .o_data(data_a), .o_push(push_a), .o_busy(busy_a),
    .o_done(done_a), .o_drop_cnt(drop_a)
  );

  time_report_tx #(.SHOW_MSEC(1'b0), .SEND_CRLF(1'b0), .DROP_W(8)) dut_s (
    .clk(clk), .rst(rst), .i_trig(trig_b), .i_enable(en),
    .hour1(hour1), .hour0(hour0), .min1(min1), .min0(min0),
    .sec1(sec1), .sec0(sec0), .msec1(msec1), .msec0(msec0),
    .i_full(full_b), .o_data(data_b), .o_push(push_b), .o_busy(busy_b),
    .o_done(done_b), .o_drop_cnt(drop_b)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (push_a) qa.push_back(data_a);
    if (busy_a) busy_cnt_a++;
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic set_digits(input logic [31:0] d);
    {hour1, hour0, min1, min0, sec1, sec0, msec1, msec0} = d;
  endtask

  task automatic pulse_a();
    trig_a = 1'b1;
    @(posedge clk); #1;
    trig_a = 1'b0;
  endtask

  task automatic wait_idle_a();
    int n = 0;
    while (busy_a && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    check_val("idle_timeout", 32'(n < 200), 32'd1);
  endtask

  task automatic check_q_exp1(input string tag);
    check_val({tag, "_len"}, qa.size(), 13);
    for (int i = 0; i < 13 && i < qa.size(); i++) check_val(tag, qa[i], exp1[i]);
  endtask

  initial begin
    set_digits(32'h1234_5678);
    #12 rst = 1'b1;
    @(posedge clk); #1;
    check_val("rst_push", push_a, 0);
    check_val("rst_data", data_a, 0);
    check_val("rst_busy", busy_a, 0);
    check_val("rst_done", done_a, 0);
    check_val("rst_drop", drop_a, 0);

    // Basic frame, cycle-exact.
    busy_cnt_a = 0;
    pulse_a();
    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      check_val("f1_push", push_a, 1);
      check_val("f1_data", data_a, exp1[i]);
      check_val("f1_done_low", done_a, 0);
    end
    @(negedge clk);
    check_val("f1_done", done_a, 1);
    check_val("f1_push_end", push_a, 0);
    @(negedge clk);
    check_val("f1_idle", busy_a, 0);
    check_val("f1_busy_cycles", busy_cnt_a, 14);

    // Short format on the second instance.
    set_digits(32'h2359_5900);
    trig_b = 1'b1;
    @(posedge clk); #1;
    trig_b = 1'b0;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      check_val("f2_push", push_b, 1);
      check_val("f2_data", data_b, exp2[i]);
    end
    @(negedge clk);
    check_val("f2_done", done_b, 1);

    // Back-pressure at byte index 4 for 5 cycles.
    set_digits(32'h1234_5678);
    @(posedge clk); #1;
    qa.delete();
    pulse_a();
    repeat (4) @(posedge clk);
    #1 full_a = 1'b1;
    @(negedge clk);
    check_val("stall_push", push_a, 0);
    check_val("stall_data", data_a, 8'h34);
    repeat (5) @(posedge clk);
    #1 full_a = 1'b0;
    wait_idle_a();
    check_q_exp1("stall_q");

    // Digits change right after the trigger: snapshot must hold.
    qa.delete();
    pulse_a();
    set_digits(32'h0);
    wait_idle_a();
    check_q_exp1("frozen_q");

    // Enable low in idle: nothing starts.
    en = 1'b0;
    pulse_a();
    @(negedge clk);
    check_val("en0_idle", busy_a, 0);
    en = 1'b1;

    // Drops while busy; disabled triggers not counted.
    set_digits(32'h1234_5678);
    pulse_a();
    pulse_a(); pulse_a(); pulse_a();
    en = 1'b0;
    pulse_a(); pulse_a();
    en = 1'b1;
    wait_idle_a();
    check_val("drop3", drop_a, 3);
    pulse_a();
    @(negedge clk);
    check_val("idle_trig_busy", busy_a, 1);
    check_val("idle_trig_nodrop", drop_a, 3);
    wait_idle_a();
    trig_a = 1'b1;
    repeat (400) @(posedge clk);
    #1 trig_a = 1'b0;
    wait_idle_a();
    check_val("drop_sat", drop_a, 255);

    // Invalid digit and mid-frame reset.
    qa.delete();
    set_digits(32'hA234_5678);
    pulse_a();
    repeat (5) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    check_val("arst_push", push_a, 0);
    check_val("arst_busy", busy_a, 0);
    check_val("arst_drop", drop_a, 0);
    check_val("arst_qlen", qa.size(), 5);
    check_val("bad_digit", (qa.size() > 0) ? qa[0] : 8'h00, 8'h3F);
    @(posedge clk); #1;
    check_val("arst_held_push", push_a, 0);
    rst = 1'b1;
    set_digits(32'h1234_5678);
    @(posedge clk); #1;
    qa.delete();
    pulse_a();
    wait_idle_a();
    check_q_exp1("post_rst_q");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
